// File: rtl/alu_pipe.sv
// Two-stage pipelined signed ALU: stage 1 registers operands, stage 2 computes
// and registers the result with zero/negative/carry/overflow flags.
module alu_pipe #(
  parameter int unsigned WIDTH    = 6,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       fxn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_ans,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SHL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  localparam logic [WIDTH-1:0] SMAX      = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SHAMT_LIM = WIDTH'(WIDTH);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  op_e              s1_op_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] ans_q, ans_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic             s2_load, in_fire;
  logic [WIDTH:0]   sum, diff;
  logic             a_msb, b_msb;
  logic signed [WIDTH-1:0] sra_res;

  // Ready looks through to out_ready so a full pipe still streams at 1/cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)        s2_valid_d = 1'b1;
    else if (out_ready) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_ADD;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_op_q <= op_e'(fxn);
      end
    end
  end

  always_comb begin
    sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    a_msb   = s1_a_q[WIDTH-1];
    b_msb   = s1_b_q[WIDTH-1];
    sra_res = $signed(s1_a_q) >>> s1_b_q;
    ans_d   = '0;
    c_d     = 1'b0;
    v_d     = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        ans_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        ans_d = diff[WIDTH-1:0];
        c_d   = diff[WIDTH];
        v_d   = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      OP_AND:  ans_d = s1_a_q & s1_b_q;
      OP_OR:   ans_d = s1_a_q | s1_b_q;
      OP_XOR:  ans_d = s1_a_q ^ s1_b_q;
      OP_SLT:  ans_d = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_SHL:  ans_d = (s1_b_q >= SHAMT_LIM) ? '0 : (s1_a_q << s1_b_q);
      OP_SRA:  ans_d = (s1_b_q >= SHAMT_LIM) ? {WIDTH{a_msb}} : WIDTH'(sra_res);
      default: ans_d = '0;
    endcase
    // Overflow direction follows the sign of a for both ADD and SUB.
    if (SATURATE && v_d) ans_d = a_msb ? SMIN : SMAX;
    z_d = (ans_d == '0);
    n_d = ans_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      ans_q      <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        ans_q <= ans_d;
        z_q   <= z_d;
        n_q   <= n_d;
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign alu_ans   = ans_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: wrapping and saturating instances share stimulus and are
// scored against an integer-arithmetic reference model.
module tb_alu_pipe;
  localparam int W    = 6;
  localparam int MAXS = 2**(W-1) - 1;
  localparam int MINS = -(2**(W-1));
  localparam int MODV = 2**W;

  typedef struct packed {
    logic [W-1:0] ans;
    logic z, n, c, v;
  } res_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] fxn = '0;
  logic in_ready0, out_valid0, z0, n0, c0, v0;
  logic in_ready1, out_valid1, z1, n1, c1, v1;
  logic [W-1:0] ans0, ans1;

  int n_checks = 0, n_errors = 0, cyc = 0;
  bit rand_bp = 1'b0;
  res_t exp0_q[$], exp1_q[$];
  int acc_cyc_q[$], out_cyc_q[$];

  alu_pipe #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .fxn(fxn), .out_valid(out_valid0), .out_ready(out_ready),
    .alu_ans(ans0), .flag_z(z0), .flag_n(n0), .flag_c(c0), .flag_v(v0));

  alu_pipe #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .fxn(fxn), .out_valid(out_valid1), .out_ready(out_ready),
    .alu_ans(ans1), .flag_z(z1), .flag_n(n1), .flag_c(c1), .flag_v(v1));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, expv, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic [2:0] tf, input bit sat);
    int ua = int'(ta);
    int ub = int'(tb_);
    int sa = (ua > MAXS) ? ua - MODV : ua;
    int sb = (ub > MAXS) ? ub - MODV : ub;
    int r = 0;
    bit c = 1'b0, v = 1'b0;
    res_t res;
    case (tf)
      3'd0: begin r = sa + sb; c = (ua + ub) >= MODV; v = (r > MAXS) || (r < MINS); end
      3'd1: begin r = sa - sb; c = ua < ub;           v = (r > MAXS) || (r < MINS); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (ub >= W) ? 0 : (ua << ub);
      default: r = (ub >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> ub);
    endcase
    if (sat && v) r = (r > 0) ? MAXS : MINS;
    res.ans = W'(r);
    res.z   = (res.ans == '0);
    res.n   = res.ans[W-1];
    res.c   = c;
    res.v   = v;
    return res;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, transfer happens at the next rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (out_valid0 && out_ready) begin
        if (exp0_q.size() == 0) check_eq("spurious_w", 32'(exp0_q.size()), 32'd1);
        else check_eq("mdl_w", 32'({ans0, z0, n0, c0, v0}), 32'(exp0_q.pop_front()));
        out_cyc_q.push_back(cyc);
      end
      if (out_valid1 && out_ready) begin
        if (exp1_q.size() == 0) check_eq("spurious_s", 32'(exp1_q.size()), 32'd1);
        else check_eq("mdl_s", 32'({ans1, z1, n1, c1, v1}), 32'(exp1_q.pop_front()));
      end
      if (in_valid && in_ready0) begin
        exp0_q.push_back(model(a, b, fxn, 1'b0));
        acc_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready1) exp1_q.push_back(model(a, b, fxn, 1'b1));
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] tf);
    bit done = 1'b0;
    a = ta; b = tb_; fxn = tf; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = in_ready0;
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("issue_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_out();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid0;
    end
    if (!seen) check_eq("out_timeout", 32'(seen), 32'd1);
    #1;
  endtask

  task automatic expect_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic [2:0] tf, input res_t e_w, input res_t e_s);
    acc_cyc_q.delete();
    out_cyc_q.delete();
    out_ready = 1'b1;
    issue(ta, tb_, tf);
    in_valid = 1'b0;
    wait_out();
    check_eq({tag, "_w"}, 32'({ans0, z0, n0, c0, v0}), 32'(e_w));
    check_eq({tag, "_s"}, 32'({ans1, z1, n1, c1, v1}), 32'(e_s));
    check_eq({tag, "_lat"}, 32'(out_cyc_q[0] - acc_cyc_q[0]), 32'd2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap;
    bit acc;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_w", 32'({out_valid0, ans0, z0, n0, c0, v0}), 32'd0);
    check_eq("rst_s", 32'({out_valid1, ans1, z1, n1, c1, v1}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    expect_one("add_pos_ovf", 6'd31, 6'd1, 3'd0, {6'b100000, 4'b0101}, {6'b011111, 4'b0001});
    expect_one("add_neg_ovf", 6'b100000, 6'b111111, 3'd0, {6'b011111, 4'b0011}, {6'b100000, 4'b0111});
    expect_one("sub_borrow", 6'b101011, 6'b110011, 3'd1, {6'b111000, 4'b0110}, {6'b111000, 4'b0110});
    expect_one("slt", 6'b111010, 6'b001010, 3'd5, {6'b000001, 4'b0000}, {6'b000001, 4'b0000});
    expect_one("sra3", 6'b100000, 6'd3, 3'd7, {6'b111100, 4'b0100}, {6'b111100, 4'b0100});
    expect_one("sra9", 6'b100000, 6'd9, 3'd7, {6'b111111, 4'b0100}, {6'b111111, 4'b0100});
    expect_one("shl6", 6'd1, 6'd6, 3'd6, {6'b000000, 4'b1000}, {6'b000000, 4'b1000});
    expect_one("shl2", 6'b000111, 6'd2, 3'd6, {6'b011100, 4'b0000}, {6'b011100, 4'b0000});
    expect_one("xor_zero", 6'b101010, 6'b101010, 3'd4, {6'b000000, 4'b1000}, {6'b000000, 4'b1000});

    // Backpressure: six stalled cycles admit exactly two operations.
    acc_cyc_q.delete();
    out_cyc_q.delete();
    out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); fxn = 3'd0; in_valid = 1'b1;
    snap = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) snap = ans0;
      if (i >= 2) begin
        check_eq("bp_valid", 32'(out_valid0), 32'd1);
        check_eq("bp_hold", 32'(ans0), 32'(snap));
      end
      acc = in_valid && in_ready0;
      @(posedge clk);
      #1;
      if (acc) begin a = W'($urandom); b = W'($urandom); end
    end
    check_eq("bp_accepts", 32'(acc_cyc_q.size()), 32'd2);
    check_eq("bp_ready", 32'(in_ready0), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("bp_drain_cnt", 32'(out_cyc_q.size()), 32'd2);
    check_eq("bp_drain_gap", 32'(out_cyc_q[1] - out_cyc_q[0]), 32'd1);

    // Full throughput: eight back-to-back operations.
    acc_cyc_q.delete();
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) issue(W'($urandom), W'($urandom), 3'($urandom));
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("tp_cnt", 32'(out_cyc_q.size()), 32'd8);
    check_eq("tp_in_span", 32'(acc_cyc_q[7] - acc_cyc_q[0]), 32'd7);
    check_eq("tp_out_span", 32'(out_cyc_q[7] - out_cyc_q[0]), 32'd7);
    check_eq("tp_lat", 32'(out_cyc_q[0] - acc_cyc_q[0]), 32'd2);

    // Random stimulus with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) issue(W'($urandom), W'($urandom), 3'($urandom));
    in_valid = 1'b0;
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("rand_drain_w", 32'(exp0_q.size()), 32'd0);
    check_eq("rand_drain_s", 32'(exp1_q.size()), 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    issue(6'd5, 6'd7, 3'd0);
    issue(6'd9, 6'd3, 3'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_w", 32'({out_valid0, ans0, z0, n0, c0, v0}), 32'd0);
    check_eq("mid_rst_s", 32'({out_valid1, ans1, z1, n1, c1, v1}), 32'd0);
    exp0_q.delete();
    exp1_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_one("post_rst", 6'd12, 6'd20, 3'd1, {6'b111000, 4'b0110}, {6'b111000, 4'b0110});
    repeat (3) @(posedge clk);
    #1;
    check_eq("post_rst_empty", 32'(exp0_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
